// File: rtl/mdu_iter.sv
// Iterative MIPS32 multiply/divide unit: one bit per clock into a HI/LO pair.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete with zero results.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_main;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MDU_DIV_EN
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [WIDTH-1:0]   rem_next;
`endif

  always_comb begin
    sign_a  = ~op[0] & a[WIDTH-1];
    sign_b  = ~op[0] & b[WIDTH-1];
    mag_a   = sign_a ? -a : a;
    mag_b   = sign_b ? -b : b;

    // acc low half holds the multiplier (mult) or the dividend/quotient (div)
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    step_next = {mul_sum, acc[WIDTH-1:1]};

    prod   = neg_main ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];

`ifdef MDU_DIV_EN
    // remainder stays below the divisor, so WIDTH bits of the difference suffice
    rem_sh   = {rem, acc[WIDTH-1]};
    ge       = rem_sh >= {1'b0, operand};
    rem_diff = rem_sh[WIDTH-1:0] - operand;
    rem_next = ge ? rem_diff : rem_sh[WIDTH-1:0];
    if (is_div) begin
      step_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
      res_hi    = neg_r ? -rem : rem;
      res_lo    = div0 ? '1 : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    end
`else
    if (is_div) begin
      res_hi = '0;
      res_lo = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      operand  <= '0;
      acc      <= '0;
`ifdef MDU_DIV_EN
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      rem      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div   <= op[1];
            neg_main <= sign_a ^ sign_b;
            operand  <= op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
`ifdef MDU_DIV_EN
            neg_r    <= sign_a;
            div0     <= op[1] & (b == '0);
            rem      <= '0;
`endif
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= step_next;
`ifdef MDU_DIV_EN
          rem <= rem_next;
`endif
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= SIGN;
        end
        SIGN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter; divide expectations follow MDU_DIV_EN.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (lat = edges after acceptance).
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy_cnt);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    lat      = -1;
    busy_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_priority: busy got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_multiply;
    logic [1:0]  vo;
    logic [31:0] va, vb, eh, el;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin vo = 2'b01; va = 32'hFFFFFFFF; vb = 32'hFFFFFFFF; eh = 32'hFFFFFFFE; el = 32'h00000001; end
        1: begin vo = 2'b00; va = 32'hFFFFFFFD; vb = 32'd5;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFF1; end
        default: begin vo = 2'b00; va = 32'h80000000; vb = 32'h80000000; eh = 32'h40000000; el = 32'h0; end
      endcase
      do_op(vo, va, vb, lat, bc);
      tests++; if (hi !== eh) begin fails++; $display("FAIL mul%0d_hi: got %h expected %h", i, hi, eh); end
      tests++; if (lo !== el) begin fails++; $display("FAIL mul%0d_lo: got %h expected %h", i, lo, el); end
      tests++; if (lat != 33) begin fails++; $display("FAIL mul%0d_latency: got %0d expected 33", i, lat); end
      if (i == 0) begin
        tests++; if (bc != 33) begin fails++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mul_busy_at_done: got %b expected 0", busy); end
      end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL mul%0d_done_pulse: got %b expected 0", i, done); end
      repeat (3) @(negedge clk);
      tests++; if (lo !== el) begin fails++; $display("FAIL mul%0d_hold_lo: got %h expected %h", i, lo, el); end
    end
  endtask

  task automatic test_divide;
    logic [1:0]  vo;
    logic [31:0] va, vb, eh, el;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin vo = 2'b11; va = 32'd100;        vb = 32'd7;        eh = 32'h2;        el = 32'hE; end
        1: begin vo = 2'b10; va = 32'hFFFFFFF9;   vb = 32'd2;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFFD; end
        2: begin vo = 2'b11; va = 32'd5;          vb = 32'd0;        eh = 32'h5;        el = 32'hFFFFFFFF; end
        default: begin vo = 2'b10; va = 32'h80000000; vb = 32'hFFFFFFFF; eh = 32'h0; el = 32'h80000000; end
      endcase
`ifndef MDU_DIV_EN
      eh = 32'h0;
      el = 32'h0;
`endif
      do_op(vo, va, vb, lat, bc);
      tests++; if (hi !== eh) begin fails++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, eh); end
      tests++; if (lo !== el) begin fails++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, el); end
      tests++; if (lat != 33) begin fails++; $display("FAIL div%0d_latency: got %0d expected 33", i, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (n == 9) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (lo !== 32'd6) begin fails++; $display("FAIL busy_ignore_lo: got %h expected 00000006", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL busy_ignore_hi: got %h expected 00000000", hi); end
    tests++; if (lat != 33) begin fails++; $display("FAIL busy_ignore_latency: got %0d expected 33", lat); end
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_op(2'b01, 32'd2, 32'd3, lat, bc);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    do_op(2'b01, 32'd7, 32'd8, lat, bc);
    tests++; if (lat != 33) begin fails++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    tests++; if (lo !== 32'd56) begin fails++; $display("FAIL b2b_lo: got %h expected 00000038", lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    int seen;
    start = 1'b1; op = 2'b10; a = 32'hFFFFFF9C; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL midrst_hi: got %h expected 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL midrst_lo: got %h expected 00000000", lo); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) seen++;
      @(negedge clk);
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
    do_op(2'b01, 32'd4, 32'd4, lat, bc);
    tests++; if (lo !== 32'd16) begin fails++; $display("FAIL midrst_after_lo: got %h expected 00000010", lo); end
    tests++; if (lat != 33) begin fails++; $display("FAIL midrst_after_latency: got %0d expected 33", lat); end
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_multiply();
    test_divide();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
